// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared constants for the game step tracker:
//   BCD_W       - width of one packed BCD digit
//   BCD_MAX     - largest legal value of one BCD digit
//   wrap_mode_e - encoding of the WRAP parameter (roll over vs. saturate)
// -----------------------------------------------------------------------------
package game_pkg;

   localparam int          BCD_W   = 4;
   localparam logic [3:0]  BCD_MAX = 4'd9;

   typedef enum logic {
      WRAP_SAT  = 1'b0,
      WRAP_ROLL = 1'b1
   } wrap_mode_e;

endpackage

// File: rtl/game_step_tracker_bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One combinational BCD digit stage of an up/down ripple counter.
// Ports:
//   d    - current digit value
//   up   - counter is stepping up this cycle
//   down - counter is stepping down this cycle
//   cin  - carry into this digit (digit must increment)
//   bin  - borrow into this digit (digit must decrement)
//   nxt  - next digit value (always 0..9)
//   cout - carry out (digit wrapped 9 -> 0)
//   bout - borrow out (digit wrapped 0 -> 9)
// -----------------------------------------------------------------------------
module bcd_digit
   import game_pkg::*;
(
   input  logic [BCD_W-1:0] d,
   input  logic             up,
   input  logic             down,
   input  logic             cin,
   input  logic             bin,
   output logic [BCD_W-1:0] nxt,
   output logic             cout,
   output logic             bout
);

   logic [BCD_W-1:0] d_s;

   // An illegal code can only appear through an upset; treat it as 9 so the
   // next value is always a legal digit.
   assign d_s = (d > BCD_MAX) ? BCD_MAX : d;

   // Next digit value with carry/borrow generation.
   always_comb begin
      nxt  = d_s;
      cout = 1'b0;
      bout = 1'b0;
      if (up && cin) begin
         if (d_s == BCD_MAX) begin
            nxt  = 4'd0;
            cout = 1'b1;
         end else begin
            nxt  = d_s + 4'd1;
         end
      end else if (down && bin) begin
         if (d_s == 4'd0) begin
            nxt  = BCD_MAX;
            bout = 1'b1;
         end else begin
            nxt  = d_s - 4'd1;
         end
      end else begin
         nxt = d_s;
      end
   end

endmodule

// File: rtl/game_step_tracker.sv
// -----------------------------------------------------------------------------
// game_step_tracker
// BCD up/down step counter with a fewest-steps best-record register.
// Parameters:
//   DIGITS - number of BCD digits (1..6)
//   WRAP   - 1: wrap around at 0 / all-nines, 0: saturate there
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   inc, dec   - step up / step down (both or neither: hold)
//   clr        - level restart: zero the count, keep the record
//   done       - level complete: record the count if it is a new best
//   q          - registered BCD step count (digit 0 in bits [3:0])
//   best       - registered BCD best record
//   best_valid - a record has been captured
//   new_best   - one-cycle pulse after the record was updated
//   limit      - one-cycle pulse after inc/dec hit a count limit
// -----------------------------------------------------------------------------
module game_step_tracker
   import game_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int WRAP   = 1
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inc,
   input  logic                  dec,
   input  logic                  clr,
   input  logic                  done,
   output logic [4*DIGITS-1:0]   q,
   output logic [4*DIGITS-1:0]   best,
   output logic                  best_valid,
   output logic                  new_best,
   output logic                  limit
);

   localparam int QW = BCD_W * DIGITS;

   logic [QW-1:0]   q_r          = {QW{1'b0}};
   logic [QW-1:0]   best_r       = {QW{1'b0}};
   logic            best_valid_r = 1'b0;
   logic            new_best_r   = 1'b0;
   logic            limit_r      = 1'b0;

   logic            step_inc_s;
   logic            step_dec_s;
   logic [DIGITS:0] carry_s;
   logic [DIGITS:0] borrow_s;
   logic [QW-1:0]   nxt_s;
   logic [QW-1:0]   q_nxt_s;
   logic            limit_hit_s;
   logic            lt_s;
   logic            decided_s;
   logic            best_take_s;

   // inc and dec together cancel out.
   assign step_inc_s  = inc & ~dec;
   assign step_dec_s  = dec & ~inc;
   assign carry_s[0]  = 1'b1;
   assign borrow_s[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         bcd_digit u_digit (
            .d    (q_r[gi*BCD_W +: BCD_W]),
            .up   (step_inc_s),
            .down (step_dec_s),
            .cin  (carry_s[gi]),
            .bin  (borrow_s[gi]),
            .nxt  (nxt_s[gi*BCD_W +: BCD_W]),
            .cout (carry_s[gi+1]),
            .bout (borrow_s[gi+1])
         );
      end
   endgenerate

   // A ripple out of the top digit means the count was at a limit; the chain
   // already produced the wrapped value, saturate mode just keeps q.
   always_comb begin
      limit_hit_s = (step_inc_s & carry_s[DIGITS]) | (step_dec_s & borrow_s[DIGITS]);
      if (limit_hit_s && (WRAP == int'(WRAP_SAT))) begin
         q_nxt_s = q_r;
      end else begin
         q_nxt_s = nxt_s;
      end
   end

   // Numeric q < best, most significant digit decides first.
   always_comb begin
      lt_s      = 1'b0;
      decided_s = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         if (decided_s) begin
            lt_s = lt_s;
         end else if (q_r[i*BCD_W +: BCD_W] < best_r[i*BCD_W +: BCD_W]) begin
            lt_s      = 1'b1;
            decided_s = 1'b1;
         end else if (q_r[i*BCD_W +: BCD_W] > best_r[i*BCD_W +: BCD_W]) begin
            lt_s      = 1'b0;
            decided_s = 1'b1;
         end else begin
            decided_s = 1'b0;
         end
      end
      best_take_s = done & (~best_valid_r | lt_s);
   end

   // Count, record and pulse registers; clr blocks stepping and done.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_r          <= {QW{1'b0}};
         best_r       <= {QW{1'b0}};
         best_valid_r <= 1'b0;
         new_best_r   <= 1'b0;
         limit_r      <= 1'b0;
      end else if (clr) begin
         q_r          <= {QW{1'b0}};
         new_best_r   <= 1'b0;
         limit_r      <= 1'b0;
      end else begin
         q_r          <= q_nxt_s;
         limit_r      <= limit_hit_s;
         new_best_r   <= best_take_s;
         if (best_take_s) begin
            best_r       <= q_r;
            best_valid_r <= 1'b1;
         end
      end
   end

   assign q          = q_r;
   assign best       = best_r;
   assign best_valid = best_valid_r;
   assign new_best   = new_best_r;
   assign limit      = limit_r;

endmodule

// File: tb/tb_game_step_tracker.sv
// -----------------------------------------------------------------------------
// tb_game_step_tracker
// Drives three trackers (2 digits wrap, 2 digits saturate, 4 digits wrap)
// from the same inputs and checks them against an integer reference model.
// -----------------------------------------------------------------------------
module tb_game_step_tracker;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic inc = 1'b0;
   logic dec = 1'b0;
   logic clr = 1'b0;
   logic done = 1'b0;

   logic [7:0]  q0, b0;
   logic [7:0]  q1, b1;
   logic [15:0] q2, b2;
   logic        v0, nb0, l0;
   logic        v1, nb1, l1;
   logic        v2, nb2, l2;

   int checks = 0;
   int errors = 0;

   // reference model state, plain integers
   int m_q[3];
   int m_best[3];
   bit m_v[3];
   bit m_nb[3];
   bit m_lim[3];
   int maxv[3]  = '{99, 99, 9999};
   bit wrapm[3] = '{1'b1, 1'b0, 1'b1};

   always #5 clk = ~clk;

   game_step_tracker #(.DIGITS(2), .WRAP(1)) dut_w (
      .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr), .done(done),
      .q(q0), .best(b0), .best_valid(v0), .new_best(nb0), .limit(l0));

   game_step_tracker #(.DIGITS(2), .WRAP(0)) dut_s (
      .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr), .done(done),
      .q(q1), .best(b1), .best_valid(v1), .new_best(nb1), .limit(l1));

   game_step_tracker #(.DIGITS(4), .WRAP(1)) dut_4 (
      .clk(clk), .rst(rst), .inc(inc), .dec(dec), .clr(clr), .done(done),
      .q(q2), .best(b2), .best_valid(v2), .new_best(nb2), .limit(l2));

   function automatic logic [15:0] to_bcd(input int v);
      int t;
      logic [15:0] r;
      t = v;
      r = 16'h0000;
      for (int i = 0; i < 4; i++) begin
         r[i*4 +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic logic [34:0] obs(input int k);
      case (k)
         0:       obs = {8'h00, q0, 8'h00, b0, v0, nb0, l0};
         1:       obs = {8'h00, q1, 8'h00, b1, v1, nb1, l1};
         default: obs = {q2, b2, v2, nb2, l2};
      endcase
   endfunction

   function automatic logic [34:0] expv(input int k);
      return {to_bcd(m_q[k]), to_bcd(m_best[k]), m_v[k], m_nb[k], m_lim[k]};
   endfunction

   // One clock: apply inputs, advance the model on the edge, settle to negedge.
   task automatic tick(input bit i, input bit d, input bit c, input bit dn, input bit r);
      inc = i; dec = d; clr = c; done = dn; rst = r;
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         if (r) begin
            m_q[k] = 0; m_best[k] = 0; m_v[k] = 1'b0; m_nb[k] = 1'b0; m_lim[k] = 1'b0;
         end else if (c) begin
            m_q[k] = 0; m_nb[k] = 1'b0; m_lim[k] = 1'b0;
         end else begin
            m_nb[k]  = 1'b0;
            m_lim[k] = 1'b0;
            if (dn && (!m_v[k] || m_q[k] < m_best[k])) begin
               m_best[k] = m_q[k]; m_v[k] = 1'b1; m_nb[k] = 1'b1;
            end
            if (i && !d) begin
               if (m_q[k] == maxv[k]) begin
                  m_lim[k] = 1'b1;
                  if (wrapm[k]) m_q[k] = 0;
               end else m_q[k] = m_q[k] + 1;
            end else if (d && !i) begin
               if (m_q[k] == 0) begin
                  m_lim[k] = 1'b1;
                  if (wrapm[k]) m_q[k] = maxv[k];
               end else m_q[k] = m_q[k] - 1;
            end
         end
      end
      @(negedge clk);
      inc = 1'b0; dec = 1'b0; clr = 1'b0; done = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset;
      tick(0, 0, 0, 0, 1);
      checks++;
      if ({q0, b0, v0, nb0, l0} !== 19'h0) begin
         errors++; $display("FAIL reset_w got %h exp 0", {q0, b0, v0, nb0, l0});
      end
      checks++;
      if ({q1, b1, v1, nb1, l1} !== 19'h0) begin
         errors++; $display("FAIL reset_s got %h exp 0", {q1, b1, v1, nb1, l1});
      end
      checks++;
      if ({q2, b2, v2, nb2, l2} !== 35'h0) begin
         errors++; $display("FAIL reset_4 got %h exp 0", {q2, b2, v2, nb2, l2});
      end
   endtask

   task automatic test_wrap_count;
      tick(0, 0, 0, 0, 1);
      repeat (99) tick(1, 0, 0, 0, 0);
      checks++;
      if ({q0, l0} !== {8'h99, 1'b0}) begin
         errors++; $display("FAIL wrap_q99 got %h exp %h", {q0, l0}, {8'h99, 1'b0});
      end
      tick(1, 0, 0, 0, 0);
      checks++;
      if ({q0, l0} !== {8'h00, 1'b1}) begin
         errors++; $display("FAIL wrap_roll got %h exp %h", {q0, l0}, {8'h00, 1'b1});
      end
      checks++;
      if ({q1, l1} !== {8'h99, 1'b1}) begin
         errors++; $display("FAIL sat_top got %h exp %h", {q1, l1}, {8'h99, 1'b1});
      end
      checks++;
      if ({q2, l2} !== {16'h0100, 1'b0}) begin
         errors++; $display("FAIL four_digit_carry got %h exp %h", {q2, l2}, {16'h0100, 1'b0});
      end
      tick(0, 0, 0, 0, 0);
      checks++;
      if ({q0, l0, l1} !== {8'h00, 1'b0, 1'b0}) begin
         errors++; $display("FAIL limit_one_cycle got %h exp %h", {q0, l0, l1}, {8'h00, 2'b00});
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (obs(k) !== expv(k)) begin
            errors++; $display("FAIL wrap_model_inst%0d got %h exp %h", k, obs(k), expv(k));
         end
      end
   endtask

   task automatic test_saturate;
      tick(0, 0, 0, 0, 1);
      tick(0, 1, 0, 0, 0);
      checks++;
      if ({q1, l1} !== {8'h00, 1'b1}) begin
         errors++; $display("FAIL sat_bottom got %h exp %h", {q1, l1}, {8'h00, 1'b1});
      end
      checks++;
      if ({q0, l0} !== {8'h99, 1'b1}) begin
         errors++; $display("FAIL wrap_bottom got %h exp %h", {q0, l0}, {8'h99, 1'b1});
      end
      checks++;
      if ({q2, l2} !== {16'h9999, 1'b1}) begin
         errors++; $display("FAIL wrap_bottom4 got %h exp %h", {q2, l2}, {16'h9999, 1'b1});
      end
      tick(0, 0, 0, 0, 1);
      repeat (9) tick(1, 0, 0, 0, 0);
      checks++;
      if (q1 !== 8'h09) begin
         errors++; $display("FAIL sat_q09 got %h exp %h", q1, 8'h09);
      end
      tick(1, 0, 0, 0, 0);
      checks++;
      if ({q1, l1} !== {8'h10, 1'b0}) begin
         errors++; $display("FAIL carry_09_10 got %h exp %h", {q1, l1}, {8'h10, 1'b0});
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (obs(k) !== expv(k)) begin
            errors++; $display("FAIL sat_model_inst%0d got %h exp %h", k, obs(k), expv(k));
         end
      end
   endtask

   task automatic test_best;
      tick(0, 0, 0, 0, 1);
      repeat (42) tick(1, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 0);
      checks++;
      if ({b0, v0, nb0} !== {8'h42, 1'b1, 1'b1}) begin
         errors++; $display("FAIL best_first got %h exp %h", {b0, v0, nb0}, {8'h42, 2'b11});
      end
      tick(0, 0, 1, 0, 0);
      checks++;
      if ({q0, b0, nb0} !== {8'h00, 8'h42, 1'b0}) begin
         errors++; $display("FAIL best_clr got %h exp %h", {q0, b0, nb0}, {8'h00, 8'h42, 1'b0});
      end
      repeat (17) tick(1, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 0);
      checks++;
      if ({b0, nb0, b2} !== {8'h17, 1'b1, 16'h0017}) begin
         errors++; $display("FAIL best_lower got %h exp %h", {b0, nb0, b2}, {8'h17, 1'b1, 16'h0017});
      end
      tick(0, 0, 1, 0, 0);
      repeat (30) tick(1, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 0);
      checks++;
      if ({b0, v0, nb0} !== {8'h17, 1'b1, 1'b0}) begin
         errors++; $display("FAIL best_higher got %h exp %h", {b0, v0, nb0}, {8'h17, 2'b10});
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (obs(k) !== expv(k)) begin
            errors++; $display("FAIL best_model_inst%0d got %h exp %h", k, obs(k), expv(k));
         end
      end
   endtask

   task automatic test_simultaneous;
      tick(0, 0, 0, 0, 1);
      repeat (5) tick(1, 0, 0, 0, 0);
      tick(1, 1, 0, 0, 0);
      checks++;
      if ({q0, l0} !== {8'h05, 1'b0}) begin
         errors++; $display("FAIL inc_dec_hold got %h exp %h", {q0, l0}, {8'h05, 1'b0});
      end
      tick(0, 0, 0, 0, 1);
      repeat (8) tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 1, 0);
      checks++;
      if ({q0, b0, v0, nb0} !== {8'h09, 8'h08, 1'b1, 1'b1}) begin
         errors++; $display("FAIL done_inc got %h exp %h", {q0, b0, v0, nb0}, {8'h09, 8'h08, 2'b11});
      end
   endtask

   task automatic test_clr_priority;
      tick(0, 0, 0, 0, 1);
      repeat (20) tick(1, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 0);
      tick(0, 0, 1, 0, 0);
      repeat (33) tick(1, 0, 0, 0, 0);
      tick(1, 0, 1, 1, 0);
      checks++;
      if ({q0, b0, v0, nb0, l0} !== {8'h00, 8'h20, 1'b1, 1'b0, 1'b0}) begin
         errors++; $display("FAIL clr_priority got %h exp %h", {q0, b0, v0, nb0, l0}, {8'h00, 8'h20, 3'b100});
      end
      repeat (57) tick(1, 0, 0, 0, 0);
      tick(1, 0, 0, 1, 1);
      checks++;
      if ({q0, b0, v0, nb0, l0} !== 19'h0) begin
         errors++; $display("FAIL rst_mid_run got %h exp 0", {q0, b0, v0, nb0, l0});
      end
      tick(1, 0, 0, 0, 0);
      checks++;
      if ({q0, v0} !== {8'h01, 1'b0}) begin
         errors++; $display("FAIL rst_resume got %h exp %h", {q0, v0}, {8'h01, 1'b0});
      end
   endtask

   task automatic test_random;
      bit i, d, c, dn, r;
      tick(0, 0, 0, 0, 1);
      for (int n = 0; n < 1500; n++) begin
         r  = ($urandom_range(255) == 0);
         c  = ($urandom_range(63) == 0);
         dn = ($urandom_range(7) == 0);
         i  = ($urandom_range(3) != 0);
         d  = ($urandom_range(3) == 0);
         tick(i, d, c, dn, r);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs(k) !== expv(k)) begin
               errors++;
               $display("FAIL random_inst%0d cycle %0d got %h exp %h", k, n, obs(k), expv(k));
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         m_q[k] = 0; m_best[k] = 0; m_v[k] = 1'b0; m_nb[k] = 1'b0; m_lim[k] = 1'b0;
      end
      @(negedge clk);
      test_reset;
      test_wrap_count;
      test_saturate;
      test_best;
      test_simultaneous;
      test_clr_priority;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/game_step_tracker.md
GAME_STEP_TRACKER -- requirements
Module: game_step_tracker

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of BCD digits in the step count (1..6).
REQ-002 SHALL have parameter WRAP, default 1; 1 = wrap-around at limits, 0 = saturate at limits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port inc, input, 1, player move executed: count up one step.
REQ-006 SHALL have port dec, input, 1, player move undone: count down one step.
REQ-007 SHALL have port clr, input, 1, level restart: zero count, keep best record.
REQ-008 SHALL have port done, input, 1, level-complete strobe: evaluate best record.
REQ-009 SHALL have port q, output, 4*DIGITS, registered BCD step count, digit 0 in bits [3:0].
REQ-010 SHALL have port best, output, 4*DIGITS, registered BCD fewest-steps record.
REQ-011 SHALL have port best_valid, output, 1, high once any record has been captured.
REQ-012 SHALL have port new_best, output, 1, one-cycle pulse when best is updated.
REQ-013 SHALL have port limit, output, 1, one-cycle pulse when inc/dec hits a count limit.

Function
REQ-014 SHALL represent q as DIGITS packed BCD digits, each 0..9; MAX = 10^DIGITS - 1 (all nines).
REQ-015 SHALL apply per-cycle priority: rst > clr > (inc/dec); done evaluated in parallel with inc/dec.
REQ-016 SHALL on inc=1, dec=0 increment q by one with BCD carry ripple (digit 9 -> 0, carry to next digit) in one cycle.
REQ-017 SHALL on dec=1, inc=0 decrement q by one with BCD borrow ripple (digit 0 -> 9, borrow from next digit) in one cycle.
REQ-018 SHALL hold q unchanged when inc and dec are both 1, and when both are 0.
REQ-019 SHALL, with WRAP=1, on inc at q=MAX load q=0 and pulse limit; on dec at q=0 load q=MAX and pulse limit.
REQ-020 SHALL, with WRAP=0, on inc at q=MAX hold q and pulse limit; on dec at q=0 hold q and pulse limit.
REQ-021 SHALL on clr load q=0, suppress inc/dec and done that cycle, leave best/best_valid unchanged, pulse nothing.
REQ-022 SHALL on done compare pre-edge q: if best_valid=0 or q < best (numeric), load best=q, set best_valid, pulse new_best next cycle.
REQ-023 SHALL on done with q >= best and best_valid=1 leave best unchanged and keep new_best low.
REQ-024 SHALL, when done coincides with inc/dec, capture the pre-update q into best while q still updates.
REQ-025 SHALL register limit and new_best; each is high for exactly the cycle after the triggering edge.
REQ-026 SHALL produce no non-BCD digit value (10..15) on q or best under any input sequence.
REQ-027 SHALL present all outputs directly from flops; no combinational input-to-output path.

Reset
REQ-028 SHALL on rst=1 at posedge clk set q=0, best=0, best_valid=0, new_best=0, limit=0, ignoring all other inputs.
REQ-029 SHALL treat rst asserted mid-operation (during any count or done cycle) identically to REQ-028, with normal operation resuming the cycle after rst deasserts.
REQ-030 SHALL use declaration initial values equal to reset values on all registers.

Structure
REQ-031 SHALL place the BCD digit width constant (4), digit max (9), and the WRAP mode encoding in shared package game_pkg.
REQ-032 SHALL instantiate DIGITS copies of sub-module bcd_digit, each taking up/down/carry-in/borrow-in and emitting next digit plus carry-out/borrow-out.
REQ-033 SHALL implement BCD magnitude compare (REQ-022) as most-significant-digit-first comparison in the top level.

Verification
REQ-034 SHALL test DIGITS=2, WRAP=1: 99 inc pulses from reset -> q=0x99; one more inc -> q=0x00, limit pulse 1 cycle.
REQ-035 SHALL test DIGITS=2, WRAP=0: dec at q=0 -> q stays 0x00, limit pulse; inc from 0x09 -> q=0x10.
REQ-036 SHALL test best tracking: done at q=0x42 -> best=0x42, best_valid=1, new_best pulse; clr, 17 incs, done -> best=0x17; clr, 30 incs, done -> best stays 0x17, no pulse.
REQ-037 SHALL test simultaneous events: inc+dec at q=0x05 -> q=0x05; done+inc at q=0x08 with best_valid=0 -> best=0x08, q=0x09.
REQ-038 SHALL test clr priority: clr+inc+done at q=0x33 -> q=0x00, best unchanged, no new_best, no limit.
REQ-039 SHALL test rst mid-run: rst at q=0x57, best=0x20 -> next cycle q=0x00, best=0x00, best_valid=0, all pulses low.
